// File: rtl/register_file.sv
// register_file: 2^ADDR_W x WIDTH register bank with one write port, one increment port and two combinational read ports.
// Define REGFILE_BYPASS_EN to forward i_D to a read port addressing the register being written in the same cycle.
module register_file #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_D,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_iaddr,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WIDTH-1:0]  o_Q_a,
  output logic [WIDTH-1:0]  o_Q_b,
  output logic              or_carry
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic             carry_q, carry_d;
  logic             inc_hit;
  // A write to the increment target discards the increment and clears the carry.
  always_comb begin
    regs_d  = regs_q;
    inc_hit = i_inc && !(i_we && i_waddr == i_iaddr);
    carry_d = i_inc ? (inc_hit && &regs_q[i_iaddr]) : carry_q;
    if (inc_hit) regs_d[i_iaddr] = regs_q[i_iaddr] + WIDTH'(1);
    if (i_we) regs_d[i_waddr] = i_D;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      regs_q  <= '{default: '0};
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
    end
  end
`ifdef REGFILE_BYPASS_EN
  assign o_Q_a = (i_we && i_waddr == i_raddr_a) ? i_D : regs_q[i_raddr_a];
  assign o_Q_b = (i_we && i_waddr == i_raddr_b) ? i_D : regs_q[i_raddr_b];
`else
  assign o_Q_a = regs_q[i_raddr_a];
  assign o_Q_b = regs_q[i_raddr_b];
`endif
  assign or_carry = carry_q;
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against an array-based reference model.
module tb_register_file;
  logic       clk = 1'b0;
  logic       rst, we, inc;
  logic [1:0] waddr, iaddr, raddr_a, raddr_b;
  logic [7:0] d, q_a, q_b;
  logic       carry;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] m [4];
  bit         mc;

  always #5 clk = ~clk;

  register_file #(.WIDTH(8), .ADDR_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_waddr(waddr), .i_D(d),
    .i_inc(inc), .i_iaddr(iaddr), .i_raddr_a(raddr_a), .i_raddr_b(raddr_b),
    .o_Q_a(q_a), .o_Q_b(q_b), .or_carry(carry)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input logic [1:0] a);
`ifdef REGFILE_BYPASS_EN
    if (we && waddr == a) return d;
`endif
    return m[a];
  endfunction

  // Drives one edge, checks the read ports just before it, then advances the model.
  task automatic cycle(input bit r, input bit we_i, input logic [1:0] wa, input logic [7:0] di,
                       input bit inc_i, input logic [1:0] ia, input logic [1:0] ra, input logic [1:0] rb);
    logic [7:0] nm [4];
    bit         nc;
    rst = r; we = we_i; waddr = wa; d = di; inc = inc_i; iaddr = ia; raddr_a = ra; raddr_b = rb;
    #1;
    check("pre_a", q_a, exp_rd(ra));
    check("pre_b", q_b, exp_rd(rb));
    nm = m;
    nc = mc;
    if (r) begin
      nm = '{default: 8'h00};
      nc = 0;
    end else begin
      if (inc_i) begin
        if (we_i && wa == ia) nc = 0;
        else begin
          nc = (m[ia] == 8'hFF);
          nm[ia] = 8'((int'(m[ia]) + 1) % 256);
        end
      end
      if (we_i) nm[wa] = di;
    end
    @(posedge clk);
    #1;
    m = nm;
    mc = nc;
    rst = 0; we = 0; inc = 0;
  endtask

  task automatic rd(input string tag, input logic [1:0] ra, input logic [1:0] rb);
    raddr_a = ra; raddr_b = rb;
    #1;
    check({tag, "_a"}, q_a, m[ra]);
    check({tag, "_b"}, q_b, m[rb]);
  endtask

  task automatic rd_all(input string tag);
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) rd(tag, 2'(a), 2'(b));
  endtask

  initial begin
    rst = 1; we = 0; inc = 0; waddr = 0; iaddr = 0; raddr_a = 0; raddr_b = 0; d = 0;
    m = '{default: 8'h00};
    mc = 0;
    @(posedge clk);
    #1;
    rst = 0;
    rd_all("rst_init");
    check("rst_init_carry", carry, 0);
    // reset overriding a write
    cycle(0, 1, 1, 8'hAA, 0, 0, 1, 1);
    rd("load_aa", 1, 1);
    cycle(1, 1, 1, 8'h55, 0, 0, 0, 0);
    rd_all("rst");
    check("rst_carry", carry, 0);
    check("rst_r1_zero", q_a, 8'h00);
    // write then sweep
    for (int i = 0; i < 4; i++) cycle(0, 1, 2'(i), 8'(8'h11 * (i + 1)), 0, 0, 0, 0);
    rd_all("sweep");
    rd("same_addr", 2, 2);
    check("same_addr_lit", q_a, 8'h33);
    // increment wrap
    cycle(0, 1, 3, 8'hFE, 0, 0, 3, 3);
    cycle(0, 0, 0, 0, 1, 3, 3, 3);
    rd("inc1", 3, 3);
    check("inc1_val", q_a, 8'hFF);
    check("inc1_carry", carry, mc);
    cycle(0, 0, 0, 0, 1, 3, 3, 3);
    rd("inc2", 3, 3);
    check("inc2_val", q_a, 8'h00);
    check("inc2_carry", carry, 1);
    cycle(0, 0, 0, 0, 0, 0, 3, 3);
    check("idle_carry", carry, 1);
    // collisions
    cycle(0, 1, 2, 8'h10, 0, 0, 2, 2);
    cycle(0, 1, 2, 8'h80, 1, 2, 2, 2);
    rd("coll_same", 2, 2);
    check("coll_same_val", q_a, 8'h80);
    check("coll_same_carry", carry, 0);
    cycle(0, 1, 1, 8'h05, 0, 0, 1, 1);
    cycle(0, 1, 2, 8'h80, 1, 1, 2, 1);
    rd("coll_diff", 2, 1);
    check("coll_diff_r2", q_a, 8'h80);
    check("coll_diff_r1", q_b, 8'h06);
    check("coll_diff_carry", carry, mc);
    // bypass (pre-edge check inside cycle uses build-dependent expectation)
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 8'h5A, 0, 0, 0, 1);
    rd("bypass_after", 0, 0);
    check("bypass_after_lit", q_a, 8'h5A);
    // write/readback loop
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 2'(i % 4), 8'(i), 0, 0, 2'(i % 4), 2'(i % 4));
      rd("loop", 2'(i % 4), 2'(i % 4));
      check("loop_lit", q_a, 32'(i));
    end
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [7:0] rd_d;
      rd_d = ($urandom_range(0, 3) == 0) ? 8'(8'hFE + $urandom_range(0, 1)) : 8'($urandom);
      cycle($urandom_range(0, 40) == 0, 1'($urandom), 2'($urandom), rd_d,
            $urandom_range(0, 2) != 0, 2'($urandom), 2'($urandom), 2'($urandom));
      check("rnd_carry", carry, mc);
      rd("rnd", 2'($urandom), 2'($urandom));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
